// File: rtl/alu_pkg.sv
// Shared opcode, polynomial and state definitions for ALU32 and its BIST engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   localparam logic [4:0] ALU_AND  = 5'b00000;
   localparam logic [4:0] ALU_OR   = 5'b00001;
   localparam logic [4:0] ALU_ADD  = 5'b00010;
   localparam logic [4:0] ALU_SUB  = 5'b01110;
   localparam logic [4:0] ALU_SLT  = 5'b01111;
   localparam logic [4:0] ALU_NOR  = 5'b11000;
   localparam logic [4:0] ALU_NAND = 5'b11001;

   // x^32 + x^22 + x^2 + x + 1, shared by the operand LFSR and the MISR
   localparam logic [31:0] BIST_POLY     = 32'h0040_0007;
   localparam int          BIST_OP_COUNT = 7;
   // position of SUB in the opcode sequence; only SUB defines the eq flag
   localparam logic [2:0]  BIST_SUB_IDX  = 3'd3;

   typedef enum logic [1:0] {IDLE, RUN, DONE} bist_state_t;

   // One Galois shift step with optional data folded in (data=0 gives a plain LFSR step)
   function automatic logic [31:0] bist_step(input logic [31:0] cur, input logic [31:0] din);
      return {cur[30:0], 1'b0} ^ (cur[31] ? BIST_POLY : 32'h0) ^ din;
   endfunction

   // Fixed opcode sequence walked by the BIST
   function automatic logic [4:0] bist_opcode(input logic [2:0] idx);
      logic [4:0] op;
      case (idx)
         3'd0:    op = ALU_AND;
         3'd1:    op = ALU_OR;
         3'd2:    op = ALU_ADD;
         3'd3:    op = ALU_SUB;
         3'd4:    op = ALU_SLT;
         3'd5:    op = ALU_NOR;
         default: op = ALU_NAND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Operand/opcode/result bundle between the BIST engine and ALU32.
// Latency: none, plain wires; ALU32 answers combinationally.
// Backpressure: none; one vector per clock.
// master: BIST side (drives alu_a/alu_b/alu_op, reads alu_s/alu_eq); slave: ALU32 side.
interface alu_bist_if;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_op;
   logic [31:0] alu_s;
   logic        alu_eq;

   modport master (output alu_a, output alu_b, output alu_op, input alu_s, input alu_eq);
   modport slave  (input alu_a, input alu_b, input alu_op, output alu_s, output alu_eq);
endinterface

// File: rtl/alu_bist_lfsr.sv
// Galois shift register usable as a plain LFSR (misr_mode=0) or as a MISR.
// Latency: state updates one clock after load/en.
// Backpressure: none; load has priority over en.
// Ports: clk/rst, load+seed (synchronous preload), en (advance), data_in+misr_mode (fold-in), state.
module alu_bist_lfsr #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] POLY      = 32'h0040_0007,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             misr_mode,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_nxt;

   always_comb begin
      state_nxt = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? POLY : '0)
                ^ (misr_mode ? data_in : '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       state <= RESET_VAL;
      else if (load) state <= seed;
      else if (en)   state <= state_nxt;
   end

endmodule

// File: rtl/alu_bist.sv
// BIST engine: walks 7 ALU32 opcodes x VECTORS pseudo-random operand pairs, compacts results in a MISR.
// Latency: 7*VECTORS cycles from the start edge to done; each result absorbed one edge after presentation.
// Backpressure: none; start is ignored while busy.
// Ports: clk, rst, start; alu (master side of alu_bist_if); busy, done, pass, signature.
module alu_bist
   import alu_pkg::*;
#(
   parameter int          VECTORS     = 64,
   parameter logic [31:0] LFSR_SEED   = 32'hACE1_2024,
   parameter logic [31:0] MISR_GOLDEN = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   alu_bist_if.master     alu,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [31:0]    signature
);

   localparam logic [15:0] LAST_VEC = 16'(VECTORS - 1);
   localparam logic [2:0]  LAST_OP  = 3'(BIST_OP_COUNT - 1);
   // vector 0 uses the seed itself, so the register is preloaded one step ahead
   localparam logic [31:0] SEED_NEXT = bist_step(LFSR_SEED, 32'h0);

   bist_state_t state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [4:0]  op_q, op_d;
   logic [15:0] vec_q, vec_d;
   logic [2:0]  idx_q, idx_d;
   logic        busy_d, done_d, pass_d;
   logic        lfsr_load, lfsr_en, misr_load, misr_en;
   logic [31:0] lfsr_q, misr_q, misr_din, misr_next;

   // eq only carries meaning for SUB, so it is masked for every other opcode
   assign misr_din  = alu.alu_s ^ {31'b0, (idx_q == BIST_SUB_IDX) & alu.alu_eq};
   assign misr_next = bist_step(misr_q, misr_din);

   alu_bist_lfsr #(.WIDTH(32), .POLY(BIST_POLY), .RESET_VAL(LFSR_SEED)) u_operand (
      .clk(clk), .rst(rst), .load(lfsr_load), .seed(SEED_NEXT), .en(lfsr_en),
      .data_in(32'h0), .misr_mode(1'b0), .state(lfsr_q)
   );

   alu_bist_lfsr #(.WIDTH(32), .POLY(BIST_POLY), .RESET_VAL(32'h0)) u_misr (
      .clk(clk), .rst(rst), .load(misr_load), .seed(32'h0), .en(misr_en),
      .data_in(misr_din), .misr_mode(1'b1), .state(misr_q)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      vec_d     = vec_q;
      idx_d     = idx_q;
      busy_d    = busy;
      done_d    = done;
      pass_d    = pass;
      lfsr_load = 1'b0;
      lfsr_en   = 1'b0;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               a_d       = LFSR_SEED;
               b_d       = LFSR_SEED;
               op_d      = bist_opcode(3'd0);
               vec_d     = 16'd0;
               idx_d     = 3'd0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               lfsr_load = 1'b1;
               misr_load = 1'b1;
            end
         end
         RUN: begin
            misr_en = 1'b1;
            if (vec_q == LAST_VEC && idx_q == LAST_OP) begin
               // alu_* hold the final vector; pass judges the signature being written now
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (misr_next == MISR_GOLDEN);
            end else begin
               lfsr_en = 1'b1;
               a_d     = lfsr_q;
               if (vec_q == LAST_VEC) begin
                  // first vector of a new opcode: equal operands so eq=1 is exercised
                  vec_d = 16'd0;
                  idx_d = idx_q + 3'd1;
                  op_d  = bist_opcode(idx_q + 3'd1);
                  b_d   = lfsr_q;
               end else begin
                  vec_d = vec_q + 16'd1;
                  b_d   = lfsr_q ^ {lfsr_q[15:0], lfsr_q[31:16]};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         op_q    <= 5'b00000;
         vec_q   <= 16'd0;
         idx_q   <= 3'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         vec_q   <= vec_d;
         idx_q   <= idx_d;
         busy    <= busy_d;
         done    <= done_d;
         pass    <= pass_d;
      end
   end

   assign alu.alu_a  = a_q;
   assign alu.alu_b  = b_q;
   assign alu.alu_op = op_q;
   assign signature  = misr_q;

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test engine that drives the ALU32 operand/opcode interface (A, alu_op, B) and compacts the returned result (S, eq) into a 32-bit MISR signature.
- Sequences every supported opcode over a run of pseudo-random operand pairs, then compares the final signature against a golden value.
- Sits beside ALU32 in the datapath and is multiplexed onto its inputs during test mode.

Parameters:
- VECTORS, 64, operand pairs applied per opcode; range 2..65535.
- LFSR_SEED, 32'hACE1_2024, initial operand LFSR state; must be nonzero.
- MISR_GOLDEN, 32'h0000_0000, expected final signature; computed by the verification model and set at integration.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a test run; sampled only in IDLE or DONE.
- alu_a  out  32  operand A to ALU32.
- alu_b  out  32  operand B to ALU32.
- alu_op  out  5  opcode to ALU32.
- alu_s  in  32  ALU32 result S (combinational from alu_a/alu_op/alu_b).
- alu_eq  in  1  ALU32 equality flag.
- busy  out  1  run in progress.
- done  out  1  run complete; sticky.
- pass  out  1  signature == MISR_GOLDEN; valid only while done=1.
- signature  out  32  current MISR contents.

Behaviour:
- Reset, asynchronous, active-high: state=IDLE; alu_a=0, alu_b=0, alu_op=5'b00000; busy=0, done=0, pass=0; signature=0; LFSR=LFSR_SEED; all counters 0.
- All outputs are registered. ALU32 is combinational, so alu_s/alu_eq for the presented vector are absorbed on the next rising edge.
- Opcode table, fixed order, index 0..6:
  - AND 00000
  - OR 00001
  - ADD 00010
  - SUB 01110
  - SLT 01111
  - NOR 11000
  - NAND 11001
- States:
  - IDLE: outputs held. start=1 -> load vector 0 of op index 0, clear MISR to 0, reload LFSR to LFSR_SEED, busy=1, go to RUN.
  - RUN: on each edge, absorb the current result into the MISR, then present the next vector. After the edge that absorbs vector VECTORS-1 of op index 6, go to DONE.
  - DONE: busy=0, done=1, pass=(MISR==MISR_GOLDEN), alu_* hold their last values. start=1 -> behaves exactly as from IDLE and clears done and pass on that edge.
- Start in RUN is ignored.
- RUN length is exactly 7*VECTORS cycles. busy is high from the edge after start through the edge entering DONE.
- Vector generation:
  - Vector 0 of each op is forced to alu_a=alu_b=current LFSR value, to exercise eq=1.
  - Other vectors: alu_a=LFSR, alu_b=LFSR ^ {LFSR[15:0],LFSR[31:16]}.
  - The LFSR advances once per presented vector and does not reset between ops.
- LFSR: 32-bit Galois, polynomial 32'h0040_0007 (x^32+x^22+x^2+x+1), shift-left form: next={l[30:0],1'b0} ^ (l[31]?POLY:0).
- MISR update: m_next = {m[30:0],1'b0} ^ (m[31]?POLY:0) ^ alu_s ^ {31'b0, eq_term}.
  - eq_term = alu_eq only when the absorbed vector's op is SUB; otherwise 0, because eq is not defined for other ops.
- Counters: vec_cnt is 16-bit and wraps to 0 at VECTORS-1, which increments op_idx (3-bit). op_idx never exceeds 6.
- Reset mid-RUN aborts immediately to the reset state; no partial pass or done is reported.
- signature is the live MISR value and is observable during RUN.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_NAND;
  - BIST_POLY;
  - BIST_OP_COUNT=7;
  - state enum {IDLE, RUN, DONE}.
- One sub-module, alu_bist_lfsr: WIDTH=32, POLY; inputs clk, rst, load, seed, en, data_in, misr_mode; output state. It is instantiated twice: once as the operand LFSR with data_in=0, once as the MISR.

Test Plan:
- Reset then start with VECTORS=2 against a behavioural ALU32 model -> busy for exactly 14 cycles; done=1; signature equals the model-computed value; pass=1 when MISR_GOLDEN is set to that value.
- First RUN cycle -> alu_op=5'b00000 and alu_a==alu_b==32'hACE1_2024. During vector 0 of SUB, alu_eq=1 is folded into the MISR.
- Stuck-at-0 injected on alu_s[0] during the NOR op -> final signature differs from golden; pass=0, done=1.
- start pulsed during RUN -> no restart; total RUN length unchanged. start pulsed in DONE -> done=0 on the next cycle and an identical signature is reproduced.
- rst asserted mid-RUN at cycle 5 -> all outputs return to reset values asynchronously (before the next clock edge); a following start gives the same golden signature.
- VECTORS=65535 smoke run -> op_idx stops at 6 without wrap; DONE is reached after 458745 RUN cycles.
